// File: rtl/busca_instrucao.sv
// Instruction-fetch / PC stage. Holds the program counter, resolves the next
// address from the control unit's branch code and the ULA flags, and runs the
// input-wait / halt state machine that produces the 'sinal' strobe.
module busca_instrucao #(
    parameter int LARGURA_PC = 10,
    parameter int PC_INICIAL = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instrucao,
    input  logic [2:0]            desvio,
    input  logic                  stop,
    input  logic                  in,
    input  logic                  jal,
    input  logic                  zero,
    input  logic                  negativo,
    input  logic [31:0]           reg_rs,
    input  logic                  botao,
    output logic [LARGURA_PC-1:0] endereco,
    output logic [LARGURA_PC-1:0] pc_mais_1,
    output logic                  sinal,
    output logic                  parado
);

    // Number of flops in the button synchronizer chain.
    localparam int SINC_ESTAGIOS = 2;

    localparam logic [LARGURA_PC-1:0] PC_RESET = PC_INICIAL[LARGURA_PC-1:0];

    // Branch/jump codes driven by the control unit.
    localparam logic [2:0] DESVIO_SEQ = 3'b000;
    localparam logic [2:0] DESVIO_JMP = 3'b001;
    localparam logic [2:0] DESVIO_BEQ = 3'b010;
    localparam logic [2:0] DESVIO_JR  = 3'b011;
    localparam logic [2:0] DESVIO_BNE = 3'b100;
    localparam logic [2:0] DESVIO_BLT = 3'b101;
    localparam logic [2:0] DESVIO_BLE = 3'b110;

    typedef enum logic [1:0] {
        EXEC    = 2'd0,
        ESPERA  = 2'd1,
        LEITURA = 2'd2,
        HALT    = 2'd3
    } estado_t;

    estado_t               estado_reg;
    estado_t               estado_next;
    logic [LARGURA_PC-1:0] pc_reg;
    logic [LARGURA_PC-1:0] pc_next;
    logic [LARGURA_PC-1:0] pc_alvo;
    logic [LARGURA_PC-1:0] pc_desvio;
    logic [31:0]           imm_ext;
    logic                  sinal_reg;
    logic [SINC_ESTAGIOS-1:0] sinc_reg;
    logic                  botao_ant_reg;
    logic                  borda;

    // jal only matters to the control unit (it stores pc_mais_1); the upper
    // instruction/register bits never reach the narrower PC.
    logic unused_bits;
    assign unused_bits = ^{jal, imm_ext[31:LARGURA_PC], reg_rs[31:LARGURA_PC]};

    assign endereco  = pc_reg;
    assign pc_mais_1 = pc_reg + 1'b1;
    assign sinal     = sinal_reg;
    assign parado    = (estado_reg == ESPERA) || (estado_reg == HALT);

    // Button synchronizer: stage 0 samples the raw pin, later stages follow.
    genvar gi;
    generate
        for (gi = 0; gi < SINC_ESTAGIOS; gi++) begin : g_sinc
            if (gi == 0) begin : g_primeiro
                // First synchronizer flop captures the asynchronous button.
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        sinc_reg[gi] <= 1'b0;
                    end else begin
                        sinc_reg[gi] <= botao;
                    end
                end
            end else begin : g_seguinte
                // Subsequent flops resolve metastability of the previous stage.
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        sinc_reg[gi] <= 1'b0;
                    end else begin
                        sinc_reg[gi] <= sinc_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Remember the previous synchronized level for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botao_ant_reg <= 1'b0;
        end else begin
            botao_ant_reg <= sinc_reg[SINC_ESTAGIOS-1];
        end
    end

    // One-cycle pulse on each synchronized rising edge; runs in every state,
    // so edges seen outside ESPERA are simply dropped.
    assign borda = sinc_reg[SINC_ESTAGIOS-1] & ~botao_ant_reg;

    // Branch target: PC+1 plus the sign-extended 16-bit immediate, wrapping.
    assign imm_ext   = {{16{instrucao[15]}}, instrucao[15:0]};
    assign pc_desvio = pc_mais_1 + imm_ext[LARGURA_PC-1:0];

    // Next-PC selection from the control unit's branch code and ULA flags.
    always_comb begin
        pc_alvo = pc_mais_1;
        case (desvio)
            DESVIO_SEQ: pc_alvo = pc_mais_1;
            DESVIO_JMP: pc_alvo = instrucao[LARGURA_PC-1:0];
            DESVIO_JR:  pc_alvo = reg_rs[LARGURA_PC-1:0];
            DESVIO_BEQ: pc_alvo = zero ? pc_desvio : pc_mais_1;
            DESVIO_BNE: pc_alvo = !zero ? pc_desvio : pc_mais_1;
            DESVIO_BLT: pc_alvo = negativo ? pc_desvio : pc_mais_1;
            DESVIO_BLE: pc_alvo = (negativo | zero) ? pc_desvio : pc_mais_1;
            default:    pc_alvo = pc_mais_1;
        endcase
    end

    // State machine next-state and next-PC; desvio only matters when running.
    always_comb begin
        estado_next = estado_reg;
        pc_next     = pc_reg;
        case (estado_reg)
            EXEC: begin
                if (!stop) begin
                    pc_next = pc_alvo;
                end else if (in) begin
                    estado_next = ESPERA;
                end else begin
                    estado_next = HALT;
                end
            end
            ESPERA: begin
                if (borda) begin
                    estado_next = LEITURA;
                end
            end
            LEITURA: begin
                // The control unit stores the input this cycle; then move on.
                pc_next     = pc_mais_1;
                estado_next = EXEC;
            end
            HALT: begin
                estado_next = HALT;
            end
            default: begin
                estado_next = EXEC;
            end
        endcase
    end

    // State, PC and the registered input-confirm strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg <= EXEC;
            pc_reg     <= PC_RESET;
            sinal_reg  <= 1'b0;
        end else begin
            estado_reg <= estado_next;
            pc_reg     <= pc_next;
            sinal_reg  <= (estado_next == LEITURA);
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed vector table, randomized next-PC run
// against an arithmetic reference model, and hand sequences for the
// input-wait, halt, reset-during-LEITURA and wrap corner cases.
module tb_busca_instrucao;

    localparam int W    = 10;
    localparam int MODN = 1 << W;

    logic          clock;
    logic          reset;
    logic [31:0]   instrucao;
    logic [2:0]    desvio;
    logic          stop;
    logic          in_cu;
    logic          jal;
    logic          zero;
    logic          negativo;
    logic [31:0]   reg_rs;
    logic          botao;
    logic [W-1:0]  endereco;
    logic [W-1:0]  pc_mais_1;
    logic          sinal;
    logic          parado;

    int checks = 0;
    int errors = 0;

    busca_instrucao #(.LARGURA_PC(W), .PC_INICIAL(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .instrucao (instrucao),
        .desvio    (desvio),
        .stop      (stop),
        .in        (in_cu),
        .jal       (jal),
        .zero      (zero),
        .negativo  (negativo),
        .reg_rs    (reg_rs),
        .botao     (botao),
        .endereco  (endereco),
        .pc_mais_1 (pc_mais_1),
        .sinal     (sinal),
        .parado    (parado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          pc_ini;
        logic [2:0]  d;
        logic        z;
        logic        n;
        logic [31:0] ins;
        logic [31:0] rs;
        int          pc_esp;
    } vetor_t;

    vetor_t tab[14];

    task automatic chk(input string nome, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference next-PC, from the branch rules with plain integer arithmetic.
    function automatic int modelo_pc(input int pc, input int d, input bit z, input bit n,
                                     input logic [31:0] ins, input logic [31:0] rs);
        int seq;
        int alvo;
        bit tomado;
        seq  = (pc + 1) % MODN;
        alvo = pc + 1 + int'($signed(ins[15:0]));
        alvo = ((alvo % MODN) + MODN) % MODN;
        tomado = 1'b0;
        case (d)
            0: return seq;
            1: return int'(ins) & (MODN - 1);
            3: return int'(rs) & (MODN - 1);
            2: tomado = z;
            4: tomado = !z;
            5: tomado = n;
            6: tomado = n || z;
            default: return seq;
        endcase
        return tomado ? alvo : seq;
    endfunction

    task automatic salta_para(input int alvo);
        stop      = 1'b0;
        in_cu     = 1'b0;
        desvio    = 3'b001;
        instrucao = 32'(alvo);
        step();
    endtask

    initial begin
        int pc_model;
        int primeiro;
        int cnt_sinal;
        bit achou;

        tab[0]  = '{20,   3'b010, 1'b1, 1'b0, 32'h0000_FFFB, 32'h0, 16};
        tab[1]  = '{20,   3'b010, 1'b0, 1'b0, 32'h0000_FFFB, 32'h0, 21};
        tab[2]  = '{20,   3'b110, 1'b0, 1'b0, 32'h0000_FFFB, 32'h0, 21};
        tab[3]  = '{0,    3'b001, 1'b0, 1'b0, 32'hDEAD_B155, 32'h0, 'h155};
        tab[4]  = '{0,    3'b011, 1'b0, 1'b0, 32'h0,         32'h0000_0403, 3};
        tab[5]  = '{20,   3'b100, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 37};
        tab[6]  = '{20,   3'b100, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 21};
        tab[7]  = '{20,   3'b101, 1'b0, 1'b1, 32'h0000_FFFB, 32'h0, 16};
        tab[8]  = '{20,   3'b110, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 26};
        tab[9]  = '{1020, 3'b010, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 2};
        tab[10] = '{2,    3'b100, 1'b0, 1'b0, 32'h0000_FFFB, 32'h0, 1022};
        tab[11] = '{20,   3'b111, 1'b1, 1'b1, 32'h0000_0005, 32'h0, 21};
        tab[12] = '{20,   3'b000, 1'b1, 1'b1, 32'h0000_0005, 32'h0, 21};
        tab[13] = '{20,   3'b101, 1'b0, 1'b0, 32'h0000_FFFB, 32'h0, 21};

        reset = 1'b0; instrucao = '0; desvio = '0; stop = 1'b0; in_cu = 1'b0;
        jal = 1'b0; zero = 1'b0; negativo = 1'b0; reg_rs = '0; botao = 1'b0;

        // Reset state
        step(); step();
        chk("reset_endereco", int'(endereco), 0);
        chk("reset_sinal", int'(sinal), 0);
        chk("reset_parado", int'(parado), 0);
        #3 reset = 1'b1;
        #1;

        // T1: sequential run
        chk("t1_pc0", int'(endereco), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("t1_pc%0d", i), int'(endereco), i);
            chk($sformatf("t1_pcm1_%0d", i), int'(pc_mais_1), i + 1);
            $display("t1 cycle %0d endereco=%0d pc_mais_1=%0d", i, endereco, pc_mais_1);
        end

        // T2/T3 plus extra branch cases from the vector table
        for (int i = 0; i < 14; i++) begin
            salta_para(tab[i].pc_ini);
            chk($sformatf("tab%0d_setup", i), int'(endereco), tab[i].pc_ini);
            desvio = tab[i].d; zero = tab[i].z; negativo = tab[i].n;
            instrucao = tab[i].ins; reg_rs = tab[i].rs;
            step();
            chk($sformatf("tab%0d_pc", i), int'(endereco), tab[i].pc_esp);
            $display("vec %0d pc=%0d desvio=%0d z=%0d n=%0d -> endereco=%0d", i,
                     tab[i].pc_ini, tab[i].d, tab[i].z, tab[i].n, endereco);
        end

        // Randomized run against the reference model
        pc_model = int'(endereco);
        for (int i = 0; i < 300; i++) begin
            desvio    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            negativo  = 1'($urandom_range(0, 1));
            instrucao = $urandom;
            reg_rs    = $urandom;
            jal       = 1'($urandom_range(0, 1));
            botao     = 1'($urandom_range(0, 1));
            pc_model  = modelo_pc(pc_model, int'(desvio), zero, negativo, instrucao, reg_rs);
            step();
            chk($sformatf("rnd%0d_pc", i), int'(endereco), pc_model);
            chk($sformatf("rnd%0d_pcm1", i), int'(pc_mais_1), (pc_model + 1) % MODN);
            chk($sformatf("rnd%0d_sinal", i), int'(sinal), 0);
        end
        botao = 1'b0; jal = 1'b0;
        step(); step(); step();

        // T4: input wait at PC=7
        salta_para(7);
        chk("t4_setup", int'(endereco), 7);
        stop = 1'b1; in_cu = 1'b1; desvio = 3'b001; instrucao = 32'd99;
        step();
        chk("t4_hold_pc", int'(endereco), 7);
        chk("t4_parado", int'(parado), 1);
        step(); step();
        chk("t4_hold_pc2", int'(endereco), 7);
        chk("t4_no_sinal", int'(sinal), 0);
        botao = 1'b1;
        primeiro = -1; cnt_sinal = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (primeiro >= 0 && i == primeiro + 1) begin
                chk("t4_pc_after", int'(endereco), 8);
                chk("t4_parado_after", int'(parado), 0);
            end
            if (sinal) begin
                cnt_sinal++;
                if (primeiro < 0) begin
                    primeiro = i;
                    chk("t4_pc_during", int'(endereco), 7);
                    stop = 1'b0; in_cu = 1'b0; desvio = 3'b000;
                end
            end
        end
        $display("t4 press: sinal first at cycle %0d, %0d cycles high", primeiro, cnt_sinal);
        chk("t4_sinal_width", cnt_sinal, 1);
        chk("t4_latency_ok", int'(primeiro >= 2 && primeiro <= 4), 1);
        botao = 1'b0;
        step(); step(); step();
        botao = 1'b1;
        cnt_sinal = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (sinal) cnt_sinal++;
        end
        chk("t4_exec_edge_ignored", cnt_sinal, 0);
        botao = 1'b0;

        // T5: halt at PC=9
        salta_para(9);
        chk("t5_setup", int'(endereco), 9);
        stop = 1'b1; in_cu = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("t5_pc%0d", i), int'(endereco), 9);
            chk($sformatf("t5_parado%0d", i), int'(parado), 1);
            chk($sformatf("t5_sinal%0d", i), int'(sinal), 0);
            desvio    = 3'b001;
            instrucao = $urandom;
            botao     = ((i % 7) < 3);
        end
        $display("t5 halt held endereco=%0d parado=%0d", endereco, parado);

        // T6: reset while in LEITURA
        reset = 1'b0; botao = 1'b0; stop = 1'b0; in_cu = 1'b0; desvio = 3'b000;
        step();
        #3 reset = 1'b1;
        salta_para(40);
        stop = 1'b1; in_cu = 1'b1;
        step(); step(); step();
        chk("t6_espera", int'(parado), 1);
        botao = 1'b1;
        achou = 1'b0;
        for (int i = 0; i < 10 && !achou; i++) begin
            step();
            if (sinal) achou = 1'b1;
        end
        chk("t6_reached_leitura", int'(achou), 1);
        reset = 1'b0;
        #1;
        chk("t6_sinal_async", int'(sinal), 0);
        chk("t6_pc_async", int'(endereco), 0);
        chk("t6_parado_async", int'(parado), 0);
        $display("t6 reset in LEITURA: sinal=%0d endereco=%0d", sinal, endereco);
        botao = 1'b0; stop = 1'b0; in_cu = 1'b0; desvio = 3'b000;
        #2 reset = 1'b1;
        step();
        chk("t6_restart", int'(endereco), 1);

        // PC wrap at 1023
        salta_para(MODN - 1);
        chk("wrap_top", int'(endereco), MODN - 1);
        chk("wrap_pcm1", int'(pc_mais_1), 0);
        desvio = 3'b000;
        step();
        chk("wrap_zero", int'(endereco), 0);
        $display("wrap: endereco=%0d", endereco);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
